// File: rtl/ones_cmp_check.sv
// Streaming one's-complement checksum checker. Words are summed mod 2^width-1 with
// an end-around-carry adder; the last word of a packet produces one result beat.

module AddMod2Nm1 #(
    parameter int width = 16,
    parameter int speed = 0
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] sum_o
);
    localparam int lv   = $clog2(width);
    localparam int nlev = (speed == 0) ? width - 1 : (speed == 1) ? 2 * lv : lv;

    // Index of the lower group merged into bit i at prefix level l, or -1 to pass through.
    function automatic int partner(input int l, input int i);
        int span;
        partner = -1;
        if (speed == 0) begin
            if (i == l + 1) partner = l;
        end else if (speed == 1) begin
            if (l < lv) begin
                span = 1 << l;
                if ((i + 1) % (2 * span) == 0) partner = i - span;
            end else begin
                span = 1 << (2 * lv - 1 - l);
                if (((i + 1) % (2 * span) == span) && (i >= 2 * span)) partner = i - span;
            end
        end else begin
            span = 1 << l;
            if ((i & span) != 0) partner = ((i >> l) << l) - 1;
        end
    endfunction

    logic [width-1:0] g0, p0, gf, pf, carry;
    logic             cout;

    assign g0 = a_i & b_i;
    assign p0 = a_i ^ b_i;

    for (genvar gl = 0; gl < nlev; gl++) begin : g_lvl
        logic [width-1:0] gin, pin, gout, pout;
        if (gl == 0) begin : g_first
            assign gin = g0;
            assign pin = p0;
        end else begin : g_chain
            assign gin = g_lvl[gl-1].gout;
            assign pin = g_lvl[gl-1].pout;
        end
        for (genvar gi = 0; gi < width; gi++) begin : g_bit
            localparam int pj = partner(gl, gi);
            if (pj >= 0) begin : g_op
                assign gout[gi] = gin[gi] | (pin[gi] & gin[pj]);
                assign pout[gi] = pin[gi] & pin[pj];
            end else begin : g_pass
                assign gout[gi] = gin[gi];
                assign pout[gi] = pin[gi];
            end
        end
    end

    assign gf = g_lvl[nlev-1].gout;
    assign pf = g_lvl[nlev-1].pout;

    // Full-span generate and propagate are exclusive; an all-propagate sum keeps 2^width-1.
    assign cout     = gf[width-1] & ~pf[width-1];
    assign carry[0] = cout;
    for (genvar gi = 1; gi < width; gi++) begin : g_carry
        assign carry[gi] = gf[gi-1] | (pf[gi-1] & cout);
    end

    assign sum_o = p0 ^ carry;
endmodule

module ones_cmp_check #(
    parameter int width     = 16,
    parameter int speed     = 0,
    parameter int cnt_width = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [width-1:0]     in_data_i,
    input  logic                 in_last_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 res_ok_o,
    output logic [width-1:0]     res_sum_o,
    output logic [cnt_width-1:0] res_count_o
);
    typedef enum logic {ACC, RESULT} state_t;

    state_t               state_reg, state_next;
    logic [width-1:0]     acc_reg, acc_next, sum_reg, sum_next, add_sum;
    logic [cnt_width-1:0] cnt_reg, cnt_next, count_reg, count_next, cnt_inc;
    logic                 ok_reg, ok_next;

    AddMod2Nm1 #(.width(width), .speed(speed)) u_add (
        .a_i  (acc_reg),
        .b_i  (in_data_i),
        .sum_o(add_sum)
    );

    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + cnt_width'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            ok_reg    <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            ok_reg    <= ok_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        ok_next    = ok_reg;
        count_next = count_reg;
        case (state_reg)
            ACC: begin
                if (in_valid_i) begin
                    if (in_last_i) begin
                        sum_next   = add_sum;
                        ok_next    = &add_sum;
                        count_next = cnt_inc;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = RESULT;
                    end else begin
                        acc_next = add_sum;
                        cnt_next = cnt_inc;
                    end
                end
            end
            RESULT: begin
                if (res_ready_i) state_next = ACC;
            end
        endcase
    end

    assign in_ready_o  = (state_reg == ACC);
    assign res_valid_o = (state_reg == RESULT);
    assign res_sum_o   = sum_reg;
    assign res_ok_o    = ok_reg;
    assign res_count_o = count_reg;
endmodule

// File: tb/tb_ones_cmp_check.sv
// Bench for ones_cmp_check: three instances (one per adder speed) share one stimulus
// stream and are checked against an arithmetic model every cycle, plus literal cases.

module tb_ones_cmp_check;
    localparam int ndut = 3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = 16'h0;
    logic        in_last   = 1'b0;
    logic        res_ready = 1'b0;

    logic        in_ready  [ndut];
    logic        res_valid [ndut];
    logic        res_ok    [ndut];
    logic [15:0] res_sum   [ndut];
    logic [1:0]  res_count [ndut];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ndut; gi++) begin : g_dut
        ones_cmp_check #(.width(16), .speed(gi), .cnt_width(2)) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[gi]),
            .in_data_i  (in_data),
            .in_last_i  (in_last),
            .res_valid_o(res_valid[gi]),
            .res_ready_i(res_ready),
            .res_ok_o   (res_ok[gi]),
            .res_sum_o  (res_sum[gi]),
            .res_count_o(res_count[gi])
        );
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, want %0h at %0t", name, k, act, exp, $time);
    endtask

    // Model: plain integer arithmetic mod 0xFFFF with the all-ones representation kept.
    int m_acc = 0, m_cnt = 0, m_sum = 0, m_count = 0, n_pkts = 0;
    bit m_res = 1'b0, m_ok = 1'b0, m_fresh = 1'b1;

    always @(negedge clk) begin : p_model
        int s;
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_res = 1'b0; m_fresh = 1'b1;
            m_sum = 0; m_ok = 1'b0; m_count = 0;
        end
        for (int k = 0; k < ndut; k++) begin
            chk("in_ready", k, 32'(in_ready[k]), 32'(!m_res));
            chk("res_valid", k, 32'(res_valid[k]), 32'(m_res));
            if (m_res || m_fresh) begin
                chk("res_sum", k, 32'(res_sum[k]), 32'(m_sum));
                chk("res_ok", k, 32'(res_ok[k]), 32'(m_ok));
                chk("res_count", k, 32'(res_count[k]), 32'(m_count));
            end
        end
        if (rst_n) begin
            if (!m_res) begin
                if (in_valid) begin
                    s = m_acc + int'(in_data);
                    if (s > 65535) s = s - 65535;
                    if (in_last) begin
                        m_sum   = s;
                        m_ok    = (s == 65535);
                        m_count = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
                        m_acc   = 0;
                        m_cnt   = 0;
                        m_res   = 1'b1;
                        m_fresh = 1'b0;
                    end else begin
                        m_acc = s;
                        m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
                    end
                end
            end else if (res_ready) begin
                m_res = 1'b0;
                n_pkts++;
                $display("pkt %0d: sum=%04h ok=%0d count=%0d", n_pkts, m_sum, m_ok, m_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [15:0] sum, input logic ok, input logic [1:0] cnt);
        for (int k = 0; k < ndut; k++) begin
            chk({name, " valid"}, k, 32'(res_valid[k]), 32'd1);
            chk({name, " ready"}, k, 32'(in_ready[k]), 32'd0);
            chk({name, " sum"}, k, 32'(res_sum[k]), 32'(sum));
            chk({name, " ok"}, k, 32'(res_ok[k]), 32'(ok));
            chk({name, " count"}, k, 32'(res_count[k]), 32'(cnt));
        end
    endtask

    task automatic expect_idle(input string name, input bit with_outputs);
        for (int k = 0; k < ndut; k++) begin
            chk({name, " ready"}, k, 32'(in_ready[k]), 32'd1);
            chk({name, " valid"}, k, 32'(res_valid[k]), 32'd0);
            if (with_outputs) begin
                chk({name, " sum"}, k, 32'(res_sum[k]), 32'd0);
                chk({name, " ok"}, k, 32'(res_ok[k]), 32'd0);
                chk({name, " count"}, k, 32'(res_count[k]), 32'd0);
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        expect_idle("reset", 1'b1);
        rst_n     = 1'b1;
        res_ready = 1'b1;

        // Valid header-like packet whose checksum closes to all-ones.
        send(16'h4500, 1'b0);
        send(16'h0030, 1'b0);
        send(16'hBACF, 1'b1);
        expect_res("t1", 16'hFFFF, 1'b1, 2'd3);
        tick();
        expect_idle("t1 after", 1'b0);

        // End-around carry: 0x8000 + 0x8000 wraps to 0x0001.
        send(16'h8000, 1'b0);
        send(16'h8000, 1'b0);
        send(16'hFFFD, 1'b1);
        expect_res("t2", 16'hFFFE, 1'b0, 2'd3);
        tick();

        // Double zero: only all-ones passes.
        send(16'h0000, 1'b1);
        expect_res("t3 zero", 16'h0000, 1'b0, 2'd1);
        tick();
        send(16'hFFFF, 1'b1);
        expect_res("t3 ones", 16'hFFFF, 1'b1, 2'd1);
        tick();

        // Result backpressure with new input words offered meanwhile.
        res_ready = 1'b0;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        expect_res("t4", 16'h3333, 1'b0, 2'd2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_last  = 1'($urandom);
            tick();
            expect_res("t4 hold", 16'h3333, 1'b0, 2'd2);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        tick();
        expect_idle("t4 release", 1'b0);
        send(16'h0001, 1'b1);
        expect_res("t4 next", 16'h0001, 1'b0, 2'd1);
        tick();

        // Gapped 5-word packet: count saturates at 3.
        for (int i = 1; i <= 5; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(16'(i * 16'h1000), (i == 5));
        end
        expect_res("t5", 16'hF000, 1'b0, 2'd3);
        tick();

        // Reset in the middle of a packet discards it.
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_idle("t6 reset", 1'b1);
        tick();
        rst_n = 1'b1;
        send(16'h1234, 1'b0);
        send(16'hEDCB, 1'b1);
        expect_res("t6", 16'hFFFF, 1'b1, 2'd2);
        tick();

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_data = 16'hFFFF;
                1:       in_data = 16'h0000;
                2:       in_data = 16'h8000;
                default: in_data = 16'($urandom);
            endcase
            in_last   = ($urandom_range(0, 5) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ones_cmp_check.md
# ones_cmp_check

Streaming one's-complement checksum checker: the receive-side counterpart of the team's end-around-carry (mod 2^n−1) adders. It accepts a packet of `width`-bit words over a valid/ready stream and accumulates them modulo 2^width−1 using an `AddMod2Nm1` instance. On the last word it presents a result beat containing the final sum, a pass/fail flag and the word count. It sits behind link/packet receive logic, which feeds it payload plus the transmitted checksum word.

## Interface
- `width`, 16, word and checksum width (≥ 2)
- `speed`, 0, passed unchanged to the internal `AddMod2Nm1` (0 serial, 1 Brent-Kung, 2 Sklansky prefix)
- `cnt_width`, 16, width of the word counter (≥ 1)

- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `in_valid_i`  in  1  input word valid
- `in_ready_o`  out  1  input word accepted when both valid and ready are high
- `in_data_i`  in  width  packet word (payload or checksum)
- `in_last_i`  in  1  marks final word of packet; qualified by valid
- `res_valid_o`  out  1  result beat valid
- `res_ready_i`  in  1  result beat consumed when both valid and ready are high
- `res_ok_o`  out  1  1 when the final sum equals all-ones (negative zero)
- `res_sum_o`  out  width  final one's-complement sum
- `res_count_o`  out  cnt_width  number of words in packet, saturating

## Operation
- Two states: ACC and RESULT. Reset state is ACC.
- Reset values:
  - `acc` = 0, `cnt` = 0.
  - `in_ready_o` = 1, `res_valid_o` = 0.
  - `res_ok_o` = 0, `res_sum_o` = 0, `res_count_o` = 0.
- ACC:
  - `in_ready_o` = 1.
  - Each accepted word updates `acc` ← AddMod2Nm1(`acc`, `in_data_i`) and `cnt` ← `cnt`+1.
  - `cnt` saturates at 2^cnt_width−1.
  - On an accepted word with `in_last_i` = 1:
    - Register `res_sum_o` = the new sum, `res_count_o` = the new count, and `res_ok_o` = (new sum == {width{1}}).
    - Clear `acc` and `cnt` to 0.
    - Move to RESULT.
  - Words with `in_valid_i` = 0 are ignored.
- RESULT:
  - `res_valid_o` = 1, `in_ready_o` = 0.
  - Result outputs are held stable until the handshake.
  - On `res_ready_i` = 1: return to ACC with `res_valid_o` = 0.
  - Result outputs keep their last values after the handshake; they are don't-care while `res_valid_o` = 0.
- Arithmetic, all mod 2^width−1 with double zero:
  - sum = a + b + carry-out (end-around carry).
  - 0xFFFF + 0x0000 = 0xFFFF, and it stays 0xFFFF.
  - 0xFFFF + 0x0001 = 0x0001.
  - 0x8000 + 0x8000 = 0x0001.
  - 0x0000 + 0x0000 = 0x0000.
- Pass criterion: the generator appends the complement of the payload sum, so a correct packet sums to 0xFFFF.
  - Sum 0x0000 is a fail. This includes an all-zero packet that has a zero checksum.
- One-word packet (`in_last_i` on the first beat) is legal; count = 1.
- Reset mid-packet or mid-result: everything returns to reset values immediately (asynchronously); the partial packet is discarded.

## Timing
- No combinational path from `in_*` to `res_*` or to `in_ready_o`. `in_ready_o` depends only on state.
- Throughput: one word per cycle in ACC.
- Latency: `res_valid_o` rises the cycle after the last word is accepted.
- A new packet may be accepted the cycle after the result handshake, so there is one idle input cycle per packet beyond the result wait.
- `res_ready_i` may be high before `res_valid_o`. In that case the result beat is consumed in its first valid cycle.
- Input valid/data may change freely while `in_ready_o` = 0; nothing is sampled then.
- The adder path is combinational within one cycle for any `speed`. Timing closure per `speed` is the integrator's choice.

## Test plan
- Reset, then a 3-word packet 0x4500, 0x0030, 0xBACF (last) with `res_ready_i` = 1:
  - `res_valid_o` one cycle after the last word.
  - `res_sum_o` = 0xFFFF, `res_ok_o` = 1, `res_count_o` = 3.
  - `in_ready_o` low for exactly 1 cycle.
- End-around carry: packet 0x8000, 0x8000, 0xFFFD (last):
  - Partial sum 0x0001.
  - Final 0xFFFE, `res_ok_o` = 0, count = 2+1 = 3.
- Double zero: one-word packet 0x0000 gives sum 0x0000 and ok = 0. One-word packet 0xFFFF gives sum 0xFFFF and ok = 1.
- Backpressure: hold `res_ready_i` = 0 for 5 cycles after the result, while `in_valid_i` = 1 with new data:
  - `in_ready_o` = 0 and result outputs stable throughout.
  - After the handshake, the next packet starts from `acc` = 0.
- Gaps and saturation, with `cnt_width` = 2:
  - 5-word packet with random valid gaps → `res_count_o` = 3.
  - Sum matches a reference mod-0xFFFF model.
- Reset asserted mid-packet after 2 words, then released:
  - Outputs at reset values.
  - Following packet 0x1234, 0xEDCB (last) gives sum 0xFFFF, ok = 1, count = 2.
